subtree_rr_arbiter: RTL and testbench
=====================================

Name: subtree_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (a config/debug access slot) among the NUM_CHILD child instances of a subtree node, one child per node instance.
- Registered one-hot grant. Burst-limited hold. One turnaround cycle between owners.
- Sits beside the child instantiations in each subtree node.

Parameters:
- NUM_CHILD, 10, number of requesters (child instances).
- MAX_BURST, 4, maximum beats per grant before forced release; range 1..255.
- TIMEOUT, 64, idle-grant cycles before watchdog release; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  NUM_CHILD  per-child request, level.
- beat_i  input  1  granted child completed one transfer this cycle.
- last_i  input  1  qualifies beat_i as the final beat of the owner's sequence.
- gnt_o  output  NUM_CHILD  one-hot grant, registered.
- gnt_valid_o  output  1  OR of gnt_o, registered.
- gnt_idx_o  output  $clog2(NUM_CHILD)  index of current owner; 0 when no grant.
- burst_cnt_o  output  8  beats taken in the current grant.
- timeout_o  output  1  one-cycle watchdog pulse (optional feature).

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears:
  - gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, burst_cnt_o=0, timeout_o=0.
  - Priority pointer ptr=0, state=IDLE.
- Reset mid-grant drops the grant immediately. No beat is counted.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching from ptr upward with wrap (ptr..NUM_CHILD-1, then 0..ptr-1).
  - Register the one-hot grant and go to GRANT.
  - Latency: gnt_o is high the cycle after req_i is first sampled high in IDLE.
  - If no request, stay in IDLE with all outputs low.
- GRANT:
  - Each beat_i increments burst_cnt_o.
  - Release when any of the following holds:
    - beat_i and last_i are both high;
    - beat_i raises the count to MAX_BURST;
    - req_i of the owner is sampled low (abandon).
  - Simultaneous release causes yield a single release.
  - On release, the next cycle: gnt_o=0, burst_cnt_o=0, ptr=(owner+1) mod NUM_CHILD (wrap 9 -> 0), state=TURN.
- TURN: exactly one cycle with no grant, then IDLE. Minimum owner-to-owner gap is 2 dead cycles.
- beat_i and last_i are ignored outside GRANT.
- The owner's req_i is never re-evaluated for priority while it holds the grant.
- Fairness: a continuously requesting child waits at most (NUM_CHILD-1) grants.
- burst_cnt_o is 8 bits and never exceeds MAX_BURST.

Optional Feature:
- Macro: SUBTREE_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of consecutive GRANT cycles without beat_i resets on each beat.
  - On reaching TIMEOUT, force release (same path as a normal release, ptr advances) and pulse timeout_o for one cycle, coincident with gnt_o falling.
- Without the macro: no counter; timeout_o is tied to 0.

Decomposition:
- Package subtree_arb_pkg holds:
  - arb_state_e enum (IDLE, GRANT, TURN);
  - default constants NUM_CHILD_DEF=10, BURST_W=8;
  - function idx_w(n) returning $clog2(n).
- One sub-module, rr_pick: combinational rotating find-first.
  - Inputs: req vector and ptr.
  - Outputs: one-hot, index, any.
  - Reused by the TURN/IDLE logic only.

Test Plan:
- Reset, then req_i=10'b00_0000_0100. Expect gnt_o=10'b00_0000_0100 and gnt_idx_o=2 one cycle later. Then beat+last: gnt drops, next owner after ptr=3.
- All requests high, owner never asserts last, beat every cycle. Expect 4 beats per grant and owners 0,1,…,9,0 in order. The 9->0 wrap is checked, with 2 dead cycles between grants.
- req_i bits 3 and 7 with ptr=5. Expect grant to 7 first, then to 3.
- Owner drops req_i mid-grant with burst_cnt_o=2. Expect release next cycle and burst_cnt_o=0.
- Assert rst_n=0 while in GRANT with burst_cnt_o=3. Expect all outputs 0 asynchronously; after release, grant restarts from ptr=0.
- With SUBTREE_ARB_TIMEOUT_EN and TIMEOUT=8: grant child 1 with no beats. Expect timeout_o pulse and gnt drop after 8 cycles, and ptr=2.

Source files
------------

// File: rtl/subtree_rr_arbiter_pkg.sv
// ============================================================================
// Module : subtree_arb_pkg
// Brief  : Shared types, default sizes and helpers for the subtree arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package subtree_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int NUM_CHILD_DEF = 10;
    localparam int BURST_W       = 8;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/subtree_rr_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotating find-first: first set request at or above
//          i_ptr, wrapping to 0. Supports N >= 2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import subtree_arb_pkg::*;
#(
    parameter int N = NUM_CHILD_DEF
) (
    input  logic [N-1:0]          i_req,
    input  logic [idx_w(N)-1:0]   i_ptr,
    output logic [N-1:0]          o_onehot,
    output logic [idx_w(N)-1:0]   o_idx,
    output logic                  o_any
);

    localparam int c_iw = idx_w(N);

    logic [N-1:0]  w_rot;
    logic [c_iw-1:0] w_off;
    logic [c_iw:0] w_sum;

    always_comb begin
        // Rotate so bit 0 is the pointer position, find the lowest set bit,
        // then map the offset back to an absolute index.
        w_rot = N'({i_req, i_req} >> i_ptr);
        w_off = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_any = 1'b1;
                w_off = c_iw'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (c_iw + 1)'(N)) begin
            w_sum = w_sum - (c_iw + 1)'(N);
        end
        o_idx    = w_sum[c_iw-1:0];
        o_onehot = o_any ? (N'(1) << o_idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/subtree_rr_arbiter.sv
// ============================================================================
// Module : subtree_rr_arbiter
// Brief  : Round-robin, burst-limited arbiter for a subtree config/debug slot.
//          Optional watchdog release enabled by SUBTREE_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module subtree_rr_arbiter
    import subtree_arb_pkg::*;
#(
    parameter int NUM_CHILD = NUM_CHILD_DEF,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CHILD-1:0]          req_i,
    input  logic                          beat_i,
    input  logic                          last_i,
    output logic [NUM_CHILD-1:0]          gnt_o,
    output logic                          gnt_valid_o,
    output logic [idx_w(NUM_CHILD)-1:0]   gnt_idx_o,
    output logic [BURST_W-1:0]            burst_cnt_o,
    output logic                          timeout_o
);

    localparam int                 c_iw        = idx_w(NUM_CHILD);
    localparam logic [BURST_W-1:0] c_max_burst = BURST_W'(MAX_BURST);
    localparam logic [c_iw-1:0]    c_last_idx  = c_iw'(NUM_CHILD - 1);

    arb_state_e          r_state;
    logic [c_iw-1:0]     r_ptr;
    logic [NUM_CHILD-1:0] r_gnt;
    logic                r_valid;
    logic [c_iw-1:0]     r_idx;
    logic [BURST_W-1:0]  r_burst;

    logic [NUM_CHILD-1:0] w_pick_onehot;
    logic [c_iw-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic [BURST_W-1:0]  w_burst_inc;
    logic                w_release;
    logic                w_timeout_hit;

    rr_pick #(
        .N (NUM_CHILD)
    ) u_rr_pick (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_comb begin
        w_burst_inc = r_burst + 1'b1;
        // Any cause releases; they merge into one release event.
        w_release   = (beat_i && last_i)
                    || (beat_i && (w_burst_inc == c_max_burst))
                    || ((req_i & r_gnt) == '0)
                    || w_timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_onehot;
                        r_valid <= 1'b1;
                        r_idx   <= w_pick_idx;
                        r_burst <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_idx   <= '0;
                        r_burst <= '0;
                        r_ptr   <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                        r_state <= TURN;
                    end else if (beat_i) begin
                        r_burst <= w_burst_inc;
                    end
                end
                TURN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SUBTREE_ARB_TIMEOUT_EN
    localparam int              c_tw      = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_to_last = c_tw'(TIMEOUT - 1);

    logic [c_tw-1:0] r_idle_cnt;
    logic            r_timeout;

    assign w_timeout_hit = (r_state == GRANT) && !beat_i && (r_idle_cnt == c_to_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if ((r_state == GRANT) && !w_release && !beat_i) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
            r_timeout <= w_timeout_hit;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
    assign w_timeout_hit    = 1'b0;
    assign timeout_o        = 1'b0;
`endif

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = r_valid;
    assign gnt_idx_o   = r_idx;
    assign burst_cnt_o = r_burst;

endmodule

`default_nettype wire

// File: tb/tb_subtree_rr_arbiter.sv
// ============================================================================
// Module : tb_subtree_rr_arbiter
// Brief  : Directed self-checking bench for subtree_rr_arbiter; the watchdog
//          scenario is included when SUBTREE_ARB_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_subtree_rr_arbiter;

`ifdef SUBTREE_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] req   = '0;
    logic       beat  = 1'b0;
    logic       last  = 1'b0;
    logic [9:0] gnt;
    logic       gnt_valid;
    logic [3:0] gnt_idx;
    logic [7:0] burst_cnt;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    subtree_rr_arbiter #(
        .NUM_CHILD (10),
        .MAX_BURST (4),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .beat_i      (beat),
        .last_i      (last),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .burst_cnt_o (burst_cnt),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        beat  = 1'b0;
        last  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req   = 10'h3FF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({gnt, gnt_valid, gnt_idx, burst_cnt, timeout} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b valid=%b idx=%0d burst=%0d to=%b required all 0",
                     gnt, gnt_valid, gnt_idx, burst_cnt, timeout);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 10'b00_0000_0100;
        tick();
        n_checks++;
        if (gnt !== 10'b00_0000_0100 || gnt_idx !== 4'd2 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b idx=%0d valid=%b required 0000000100 idx 2 valid 1",
                     gnt, gnt_idx, gnt_valid);
        end
        beat = 1'b1; last = 1'b1;
        req  = 10'b00_0000_1111;
        tick();
        beat = 1'b0; last = 1'b0;
        n_checks++;
        if (gnt !== 10'b0 || gnt_valid !== 1'b0 || burst_cnt !== 8'd0 || gnt_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL last_release: gnt=%b valid=%b burst=%0d idx=%0d required all 0",
                     gnt, gnt_valid, burst_cnt, gnt_idx);
        end
        tick();
        n_checks++;
        if (gnt !== 10'b0) begin
            n_fail++;
            $display("FAIL turn_gap: gnt=%b required 0", gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 10'b00_0000_1000 || gnt_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL next_after_ptr3: gnt=%b idx=%0d required 0000001000 idx 3", gnt, gnt_idx);
        end
        req = '0;
        tick();
    endtask

    task automatic test_burst_rotation();
        do_reset();
        req  = 10'h3FF;
        beat = 1'b1;
        last = 1'b0;
        for (int g = 0; g < 11; g++) begin
            int own = g % 10;
            tick();
            n_checks++;
            if (gnt !== (10'b1 << own) || gnt_idx !== 4'(own) || burst_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL rot_owner[%0d]: gnt=%b idx=%0d burst=%0d required owner %0d burst 0",
                         g, gnt, gnt_idx, burst_cnt, own);
            end
            for (int b = 1; b <= 3; b++) begin
                tick();
                n_checks++;
                if (burst_cnt !== 8'(b) || gnt !== (10'b1 << own)) begin
                    n_fail++;
                    $display("FAIL rot_burst[%0d.%0d]: burst=%0d gnt=%b required burst %0d owner %0d",
                             g, b, burst_cnt, gnt, b, own);
                end
            end
            for (int d = 0; d < 2; d++) begin
                tick();
                n_checks++;
                if (gnt !== 10'b0 || burst_cnt !== 8'd0) begin
                    n_fail++;
                    $display("FAIL rot_dead[%0d.%0d]: gnt=%b burst=%0d required 0 0", g, d, gnt, burst_cnt);
                end
            end
        end
        req  = '0;
        beat = 1'b0;
        tick();
    endtask

    task automatic test_ptr_wrap_search();
        do_reset();
        req = 10'b00_0001_0000;
        tick();
        n_checks++;
        if (gnt !== 10'b00_0001_0000) begin
            n_fail++;
            $display("FAIL ptr_setup: gnt=%b required 0000010000", gnt);
        end
        req = 10'b00_1000_1000;
        tick();
        tick();
        tick();
        n_checks++;
        if (gnt !== 10'b00_1000_0000 || gnt_idx !== 4'd7) begin
            n_fail++;
            $display("FAIL ptr5_first: gnt=%b idx=%0d required 0010000000 idx 7", gnt, gnt_idx);
        end
        beat = 1'b1; last = 1'b1;
        tick();
        beat = 1'b0; last = 1'b0;
        tick();
        tick();
        n_checks++;
        if (gnt !== 10'b00_0000_1000 || gnt_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL ptr8_wrap: gnt=%b idx=%0d required 0000001000 idx 3", gnt, gnt_idx);
        end
        req = '0;
        tick();
    endtask

    task automatic test_abandon();
        do_reset();
        req = 10'b00_0010_0000;
        tick();
        beat = 1'b1;
        tick();
        tick();
        n_checks++;
        if (burst_cnt !== 8'd2 || gnt !== 10'b00_0010_0000) begin
            n_fail++;
            $display("FAIL abandon_pre: burst=%0d gnt=%b required 2 0000100000", burst_cnt, gnt);
        end
        beat = 1'b0;
        req  = '0;
        tick();
        n_checks++;
        if (gnt !== 10'b0 || burst_cnt !== 8'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon_release: gnt=%b burst=%0d valid=%b required 0 0 0",
                     gnt, burst_cnt, gnt_valid);
        end
        req = 10'b00_0100_0001;
        tick();
        tick();
        n_checks++;
        if (gnt !== 10'b00_0100_0000 || gnt_idx !== 4'd6) begin
            n_fail++;
            $display("FAIL abandon_ptr: gnt=%b idx=%0d required 0001000000 idx 6", gnt, gnt_idx);
        end
        req = '0;
        tick();
    endtask

    task automatic test_beat_ignored();
        do_reset();
        beat = 1'b1; last = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (burst_cnt !== 8'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL beat_idle: burst=%0d valid=%b required 0 0", burst_cnt, gnt_valid);
        end
        beat = 1'b0; last = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 10'b01_0000_0000;
        tick();
        beat = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (burst_cnt !== 8'd3 || gnt !== 10'b01_0000_0000) begin
            n_fail++;
            $display("FAIL areset_pre: burst=%0d gnt=%b required 3 0100000000", burst_cnt, gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, gnt_valid, gnt_idx, burst_cnt, timeout} !== 24'h0) begin
            n_fail++;
            $display("FAIL areset_async: gnt=%b valid=%b idx=%0d burst=%0d to=%b required all 0",
                     gnt, gnt_valid, gnt_idx, burst_cnt, timeout);
        end
        beat = 1'b0;
        @(negedge clk);
        req   = 10'b01_0000_0010;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 10'b00_0000_0010 || gnt_idx !== 4'd1 || burst_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL areset_restart: gnt=%b idx=%0d burst=%0d required 0000000010 idx 1 burst 0",
                     gnt, gnt_idx, burst_cnt);
        end
        req = '0;
        tick();
    endtask

`ifdef SUBTREE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 10'b00_0000_0010;
        tick();
        for (int c = 1; c < 8; c++) begin
            tick();
            n_checks++;
            if (gnt !== 10'b00_0000_0010 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold[%0d]: gnt=%b to=%b required 0000000010 0", c, gnt, timeout);
            end
        end
        req = 10'b00_0000_0111;
        tick();
        n_checks++;
        if (gnt !== 10'b0 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_pulse: gnt=%b to=%b required 0 1", gnt, timeout);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_one_cycle: to=%b required 0", timeout);
        end
        tick();
        n_checks++;
        if (gnt !== 10'b00_0000_0100 || gnt_idx !== 4'd2) begin
            n_fail++;
            $display("FAIL to_ptr: gnt=%b idx=%0d required 0000000100 idx 2", gnt, gnt_idx);
        end
        req = '0;
        tick();
    endtask
`else
    task automatic test_timeout();
        bit saw_pulse;
        saw_pulse = 1'b0;
        do_reset();
        req = 10'b00_0000_0010;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (timeout !== 1'b0) saw_pulse = 1'b1;
        end
        n_checks++;
        if (saw_pulse !== 1'b0 || gnt !== 10'b00_0000_0010) begin
            n_fail++;
            $display("FAIL no_watchdog: pulse=%b gnt=%b required 0 0000000010", saw_pulse, gnt);
        end
        req = '0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_burst_rotation();
        test_ptr_wrap_search();
        test_abandon();
        test_beat_ignored();
        test_async_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
